mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin packet arbiter that shares one 8:1 datapath multiplexer (MUX8) between eight requesters in the DSP slice. It selects one requester and drives the MUX8 select. It holds that grant until the requester's packet ends (`last`) or an idle watchdog fires. The selected beat is presented on a registered valid/ready output stage.

## Interface
- `WIDTH`, 18, data width of each requester lane and of the output.
- `TIMEOUT`, 16, idle cycles allowed for a locked requester before forced release; legal range 2..255.

- `CLK`  in  1  single clock, rising edge.
- `RST_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  per-requester valid; bit i qualifies lane i.
- `last`  in  8  per-requester end-of-packet, sampled with `req[i]`.
- `in_data`  in  8*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- `gnt`  out  8  one-hot ready to requester i; a beat transfers when `req[i] && gnt[i]`.
- `out_data`  out  WIDTH  registered muxed data.
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  registered `last` of the held beat.
- `out_src`  out  3  index of the requester that produced the held beat.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `timeout_err`  out  1  one-cycle pulse on watchdog release.

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - If `req != 0`, choose the first set bit scanning upward from `ptr` with wrap 7→0.
  - Register that index into `sel` and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `gnt[sel] = (!out_valid || out_ready)`; all other `gnt` bits are 0.
  - `gnt` is 0 in IDLE.
- Accepted beat:
  - Load `out_data` from MUX8(`in_data` lanes, `sel`), `out_last <= last[sel]`, `out_src <= sel`, `out_valid <= 1`.
  - If `last[sel]`, go to IDLE and set `ptr <= sel+1` (mod 8).
- Output stage: if there is no accepted beat and `out_ready` is high, `out_valid <= 0`.
- Watchdog:
  - `idle_cnt` increments in BUSY on each cycle with `req[sel]==0` and clears on any accepted beat.
  - At `idle_cnt == TIMEOUT-1`: pulse `timeout_err`, go to IDLE, set `ptr <= sel+1`, clear `idle_cnt`.
- Requests on lanes other than `sel` are ignored while in BUSY; their `last` inputs are don't-care.
- Reset values: state IDLE, `ptr`=0, `sel`=0, `idle_cnt`=0, `gnt`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `out_src`=0, `timeout_err`=0.

## Timing
- Arbitration latency: `req` seen in IDLE at cycle N → `gnt` at N+1 → `out_valid` at N+2.
- Throughput is 1 beat/cycle within a packet when `out_ready` is held high.
- There is exactly one IDLE bubble cycle between packets.
- Backpressure: with `out_valid=1` and `out_ready=0`, `gnt` is 0 and the output holds stable.
- Simultaneous events:
  - A beat accepted in the same cycle `idle_cnt` would expire is a transfer, not a timeout.
  - A final `last` beat has priority over the watchdog.
- Single-beat packet (`req` and `last` both high on the first granted beat) returns to IDLE after one beat.
- Asserting `RST_n` low mid-packet forces all reset values immediately. No partial beat is emitted, and `ptr` restarts at 0.

## Structure
- Shared package/include holds:
  - `NREQ=8` and `SEL_W=3`.
  - FSM encodings `ST_IDLE=1'b0`, `ST_BUSY=1'b1`.
  - The round-robin find-first-from-pointer function.
- Sub-module: one MUX8 instance (`WIDTH` passed through, `sel` from the arbiter register) feeding the output register.
- All sequential logic sits in one always block with async reset. Arbitration and `gnt` are combinational.

## Test plan
- Reset, then `req=8'h01` with `last[0]=1` and lane0=`18'h00AA`, `out_ready=1` → `gnt=8'h01` at cycle 1; `out_data=00AA`, `out_src=0`, `out_last=1` at cycle 2; FSM back in IDLE.
- `req=8'hFF` held, all beats with `last=1` → grant order 0,1,2,…,7,0, one grant every 2 cycles.
- Requester 3 sends 4-beat packet (lane values 1,2,3,4; `last` on 4th) while `req[5]` is asserted → four consecutive `out_src=3` beats, then requester 5.
- During a packet, hold `out_ready=0` for 3 cycles → `gnt=0` and `out_data` stable for those cycles; no beat lost or duplicated.
- Locked requester 2 drops `req` for `TIMEOUT` (16) cycles → `timeout_err` pulses once after the 16th idle cycle; next grant goes to the lowest requesting index ≥3.
- Assert `RST_n=0` mid-packet → all outputs 0 immediately; after release, `req=8'h80` is granted with `ptr` restarted at 0.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// rtl/mux8_rr_arbiter_pkg.sv - shared constants, FSM encoding and round-robin pick for mux8_rr_arbiter
package mux8_rr_arbiter_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // First set bit of req scanning upward from ptr, wrapping 7 -> 0.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NREQ-1:0]  req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux8.sv
// rtl/mux8_rr_arbiter_mux8.sv - 8:1 lane multiplexer shared by the arbiter
module mux8_rr_arbiter_mux8
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [NREQ*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      y
);

    logic [WIDTH-1:0] lanes [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lanes[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign y = lanes[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin packet arbiter driving a shared MUX8 into a registered output stage
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] in_data,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_src,
    input  logic                  out_ready,
    output logic                  timeout_err
);

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] pick;
    logic [7:0]       idle_cnt;
    logic [WIDTH-1:0] mux_y;
    logic             accept;
    logic             expire;

    mux8_rr_arbiter_mux8 #(
        .WIDTH (WIDTH)
    ) u_mux8 (
        .in_data (in_data),
        .sel     (sel),
        .y       (mux_y)
    );

    assign pick = rr_pick(req, ptr);

    always_comb begin
        gnt = '0;
        if (state == ST_BUSY && (!out_valid || out_ready)) begin
            gnt[sel] = 1'b1;
        end
    end

    assign accept = req[sel] && gnt[sel];
    // A beat landing on the expiry cycle is a transfer, never a timeout.
    assign expire = (state == ST_BUSY) && !accept && (idle_cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|req) state_nxt = ST_BUSY;
            ST_BUSY: if ((accept && last[sel]) || expire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            sel         <= '0;
            idle_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_src     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= 1'b0;

            if (state == ST_IDLE && |req) begin
                sel <= pick;
            end

            if (accept) begin
                out_data  <= mux_y;
                out_last  <= last[sel];
                out_src   <= sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == ST_BUSY) begin
                if (accept) begin
                    idle_cnt <= '0;
                    if (last[sel]) ptr <= sel + 3'd1;
                end else if (expire) begin
                    timeout_err <= 1'b1;
                    idle_cnt    <= '0;
                    ptr         <= sel + 3'd1;
                end else if (!req[sel]) begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed vector bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

    localparam int W  = 18;
    localparam int TO = 16;

    logic            CLK = 1'b0;
    logic            RST_n = 1'b0;
    logic [7:0]      req = '0;
    logic [7:0]      last = '0;
    logic [8*W-1:0]  in_data = '0;
    logic            out_ready = 1'b1;
    logic [7:0]      gnt;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [2:0]      out_src;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;

    mux8_rr_arbiter #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .req         (req),
        .last        (last),
        .in_data     (in_data),
        .gnt         (gnt),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]   req;
        logic [7:0]   last;
        logic         rdy;
        logic [11:0]  dat;
        logic [7:0]   egnt;
        logic         eov;
        logic [2:0]   esrc;
        logic         elast;
        logic [17:0]  edata;
        logic         eterr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] l, input logic rd,
                                input logic [11:0] d, input logic [7:0] eg, input logic eov,
                                input logic [2:0] es, input logic el, input logic [17:0] ed,
                                input logic et);
        vec_t v;
        v.req = r; v.last = l; v.rdy = rd; v.dat = d;
        v.egnt = eg; v.eov = eov; v.esrc = es; v.elast = el; v.edata = ed; v.eterr = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane i carries {i, dat} so the source is visible in the data.
    task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic rd, input logic [11:0] d);
        req = r;
        last = l;
        out_ready = rd;
        for (int i = 0; i < 8; i++) begin
            in_data[i*W +: W] = (18'(i) << 12) | 18'(d);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        drive(v.req, v.last, v.rdy, v.dat);
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(v.egnt));
        @(posedge CLK);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.eov));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(v.eterr));
        if (v.eov) begin
            chk({tag, ".out_data"}, 32'(out_data), 32'(v.edata));
            chk({tag, ".out_src"}, 32'(out_src), 32'(v.esrc));
            chk({tag, ".out_last"}, 32'(out_last), 32'(v.elast));
        end
    endtask

    initial begin
        logic [2:0] idx;

        // single-beat packet from lane 0
        tbl.push_back(mk(8'h01, 8'h01, 1, 12'h0AA, 8'h00, 0, 0, 0, 18'h0, 0));
        tbl.push_back(mk(8'h01, 8'h01, 1, 12'h0AA, 8'h01, 1, 0, 1, 18'h000AA, 0));
        tbl.push_back(mk(8'h00, 8'h00, 1, 12'h000, 8'h00, 0, 0, 0, 18'h0, 0));
        // all requesting, single-beat packets: rotation 1..7 then wrap to 0
        for (int k = 1; k <= 8; k++) begin
            idx = 3'(k % 8);
            tbl.push_back(mk(8'hFF, 8'hFF, 1, 12'h0F0, 8'h00, 0, 0, 0, 18'h0, 0));
            tbl.push_back(mk(8'hFF, 8'hFF, 1, 12'h0F0, 8'h01 << idx, 1, idx, 1,
                             (18'(idx) << 12) | 18'h0F0, 0));
        end
        // 4-beat packet on lane 3 while lane 5 waits
        tbl.push_back(mk(8'h28, 8'h20, 1, 12'h000, 8'h00, 0, 0, 0, 18'h0, 0));
        tbl.push_back(mk(8'h28, 8'h20, 1, 12'h001, 8'h08, 1, 3, 0, 18'h03001, 0));
        tbl.push_back(mk(8'h28, 8'h20, 1, 12'h002, 8'h08, 1, 3, 0, 18'h03002, 0));
        tbl.push_back(mk(8'h28, 8'h20, 1, 12'h003, 8'h08, 1, 3, 0, 18'h03003, 0));
        tbl.push_back(mk(8'h28, 8'h28, 1, 12'h004, 8'h08, 1, 3, 1, 18'h03004, 0));
        tbl.push_back(mk(8'h20, 8'h20, 1, 12'h005, 8'h00, 0, 0, 0, 18'h0, 0));
        tbl.push_back(mk(8'h20, 8'h20, 1, 12'h005, 8'h20, 1, 5, 1, 18'h05005, 0));
        tbl.push_back(mk(8'h00, 8'h00, 1, 12'h000, 8'h00, 0, 0, 0, 18'h0, 0));
        // backpressure for 3 cycles in a lane 6 packet
        tbl.push_back(mk(8'h40, 8'h00, 1, 12'h011, 8'h00, 0, 0, 0, 18'h0, 0));
        tbl.push_back(mk(8'h40, 8'h00, 1, 12'h011, 8'h40, 1, 6, 0, 18'h06011, 0));
        tbl.push_back(mk(8'h40, 8'h00, 0, 12'h022, 8'h00, 1, 6, 0, 18'h06011, 0));
        tbl.push_back(mk(8'h40, 8'h00, 0, 12'h033, 8'h00, 1, 6, 0, 18'h06011, 0));
        tbl.push_back(mk(8'h40, 8'h00, 0, 12'h022, 8'h00, 1, 6, 0, 18'h06011, 0));
        tbl.push_back(mk(8'h40, 8'h00, 1, 12'h022, 8'h40, 1, 6, 0, 18'h06022, 0));
        tbl.push_back(mk(8'h40, 8'h40, 1, 12'h033, 8'h40, 1, 6, 1, 18'h06033, 0));
        tbl.push_back(mk(8'h00, 8'h00, 1, 12'h000, 8'h00, 0, 0, 0, 18'h0, 0));

        repeat (3) @(posedge CLK);
        #1;
        chk("reset.gnt", 32'(gnt), 32'h0);
        chk("reset.out_valid", 32'(out_valid), 32'h0);
        chk("reset.out_data", 32'(out_data), 32'h0);
        chk("reset.out_src", 32'(out_src), 32'h0);
        chk("reset.out_last", 32'(out_last), 32'h0);
        chk("reset.timeout_err", 32'(timeout_err), 32'h0);
        RST_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl[%0d]", i));

        // watchdog: lane 2 goes silent for TIMEOUT cycles
        step(mk(8'h04, 8'h00, 1, 12'h055, 8'h00, 0, 0, 0, 18'h0, 0), "to.arb");
        step(mk(8'h04, 8'h00, 1, 12'h055, 8'h04, 1, 2, 0, 18'h02055, 0), "to.beat");
        for (int k = 1; k <= TO; k++) begin
            drive(8'h00, 8'h00, 1, 12'h000);
            #1;
            chk($sformatf("to.idle%0d.gnt", k), 32'(gnt), 32'h04);
            @(posedge CLK);
            #1;
            chk($sformatf("to.idle%0d.timeout_err", k), 32'(timeout_err), 32'(k == TO));
        end
        step(mk(8'h0A, 8'h08, 1, 12'h077, 8'h00, 0, 0, 0, 18'h0, 0), "to.rearb");
        step(mk(8'h0A, 8'h08, 1, 12'h077, 8'h08, 1, 3, 1, 18'h03077, 0), "to.next");
        step(mk(8'h00, 8'h00, 1, 12'h000, 8'h00, 0, 0, 0, 18'h0, 0), "to.drain");

        // beat accepted on the would-be expiry cycle is a transfer
        step(mk(8'h02, 8'h00, 1, 12'h010, 8'h00, 0, 0, 0, 18'h0, 0), "edge.arb");
        step(mk(8'h02, 8'h00, 1, 12'h010, 8'h02, 1, 1, 0, 18'h01010, 0), "edge.beat");
        for (int k = 1; k < TO; k++) begin
            drive(8'h00, 8'h00, 1, 12'h000);
            @(posedge CLK);
            #1;
            chk($sformatf("edge.idle%0d.timeout_err", k), 32'(timeout_err), 32'h0);
        end
        step(mk(8'h02, 8'h02, 1, 12'h011, 8'h02, 1, 1, 1, 18'h01011, 0), "edge.last");
        step(mk(8'h00, 8'h00, 1, 12'h000, 8'h00, 0, 0, 0, 18'h0, 0), "edge.drain");

        // reset mid-packet on lane 6
        step(mk(8'h40, 8'h00, 1, 12'h0B0, 8'h00, 0, 0, 0, 18'h0, 0), "rst.arb");
        step(mk(8'h40, 8'h00, 1, 12'h0B0, 8'h40, 1, 6, 0, 18'h060B0, 0), "rst.beat");
        #2;
        RST_n = 1'b0;
        #1;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_data", 32'(out_data), 32'h0);
        chk("rst.out_src", 32'(out_src), 32'h0);
        chk("rst.out_last", 32'(out_last), 32'h0);
        @(posedge CLK);
        #1;
        chk("rst.hold.out_valid", 32'(out_valid), 32'h0);
        RST_n = 1'b1;
        step(mk(8'h21, 8'h21, 1, 12'h00C, 8'h00, 0, 0, 0, 18'h0, 0), "post.arb0");
        step(mk(8'h21, 8'h21, 1, 12'h00C, 8'h01, 1, 0, 1, 18'h0000C, 0), "post.ptr0");
        step(mk(8'h00, 8'h00, 1, 12'h000, 8'h00, 0, 0, 0, 18'h0, 0), "post.gap");
        step(mk(8'h80, 8'h80, 1, 12'h00D, 8'h00, 0, 0, 0, 18'h0, 0), "post.arb7");
        step(mk(8'h80, 8'h80, 1, 12'h00D, 8'h80, 1, 7, 1, 18'h0700D, 0), "post.lane7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
